// File: rtl/dm_store_buffer_if.sv
// rtl/dm_store_buffer_if.sv - store/load request, data-memory and status bundle for dm_store_buffer
// Signal suffixes are from the buffer's point of view (slave modport).
interface dm_store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 32
);
  logic                   st_req_i;
  logic [AW-1:0]          st_addr_i;
  logic [DW-1:0]          st_data_i;
  logic                   st_ready_o;
  logic                   ld_req_i;
  logic [AW-1:0]          ld_addr_i;
  logic                   ld_busy_o;
  logic                   ld_valid_o;
  logic [DW-1:0]          ld_data_o;
  logic [AW-1:0]          dm_read_addr_o;
  logic [AW-1:0]          dm_write_addr_o;
  logic [DW-1:0]          dm_write_data_o;
  logic                   dm_we_o;
  logic [DW-1:0]          dm_read_data_i;
  logic [$clog2(DEPTH):0] buf_count_o;

  modport master (
    output st_req_i, st_addr_i, st_data_i, ld_req_i, ld_addr_i, dm_read_data_i,
    input  st_ready_o, ld_busy_o, ld_valid_o, ld_data_o, dm_read_addr_o,
           dm_write_addr_o, dm_write_data_o, dm_we_o, buf_count_o
  );

  modport slave (
    input  st_req_i, st_addr_i, st_data_i, ld_req_i, ld_addr_i, dm_read_data_i,
    output st_ready_o, ld_busy_o, ld_valid_o, ld_data_o, dm_read_addr_o,
           dm_write_addr_o, dm_write_data_o, dm_we_o, buf_count_o
  );
endinterface

// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - posted-write store FIFO and load sequencer in front of SISC data memory
// Optional: LOAD_FORWARD_EN returns buffered data on a load address hit instead of draining.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  dm_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, LD_CHK, LD_CAP} state_t;

  state_t        state_q;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ld_busy_q, ld_valid_q, we_q;
  logic [AW-1:0] ld_addr_q, rd_addr_q, wr_addr_q;
  logic [DW-1:0] ld_data_q, wr_data_q;
  logic          push, pop, ld_accept, hit;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
`ifdef LOAD_FORWARD_EN
  logic [DW-1:0] hit_data;
`endif

  assign bus.st_ready_o      = (count_q != CW'(DEPTH));
  assign bus.ld_busy_o       = ld_busy_q;
  assign bus.ld_valid_o      = ld_valid_q;
  assign bus.ld_data_o       = ld_data_q;
  assign bus.dm_read_addr_o  = rd_addr_q;
  assign bus.dm_write_addr_o = wr_addr_q;
  assign bus.dm_write_data_o = wr_data_q;
  assign bus.dm_we_o         = we_q;
  assign bus.buf_count_o     = count_q;

  assign push      = bus.st_req_i && bus.st_ready_o;
  assign pop       = (state_q == W_HOLD);
  assign ld_accept = bus.ld_req_i && !ld_busy_q;
  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Walk oldest to youngest so the last match seen is the newest store.
  always_comb begin
    hit = 1'b0;
`ifdef LOAD_FORWARD_EN
    hit_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && addr_mem[rd_ptr_q + PW'(i)] == ld_addr_q) begin
        hit = 1'b1;
`ifdef LOAD_FORWARD_EN
        hit_data = data_mem[rd_ptr_q + PW'(i)];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.st_addr_i;
      data_mem[wr_ptr_q] <= bus.st_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ld_busy_q  <= 1'b0;
      ld_valid_q <= 1'b0;
      we_q       <= 1'b0;
      ld_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      ld_data_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ld_valid_q <= 1'b0;
      if (ld_accept) begin
        ld_busy_q <= 1'b1;
        ld_addr_q <= bus.ld_addr_i;
      end
      unique case (state_q)
        IDLE: begin
          if (ld_accept || ld_busy_q) begin
            state_q <= LD_CHK;
          end else if (count_q != '0) begin
            wr_addr_q <= head_addr;
            wr_data_q <= head_data;
            state_q   <= W_SETUP;
          end else if (push) begin
            // Empty buffer: the entry being pushed is the head next cycle.
            wr_addr_q <= bus.st_addr_i;
            wr_data_q <= bus.st_data_i;
            state_q   <= W_SETUP;
          end
        end
        W_SETUP: begin
          we_q    <= 1'b1;
          state_q <= W_PULSE;
        end
        W_PULSE: begin
          we_q    <= 1'b0;
          state_q <= W_HOLD;
        end
        W_HOLD: state_q <= IDLE;
        LD_CHK: begin
          if (hit) begin
`ifdef LOAD_FORWARD_EN
            ld_data_q  <= hit_data;
            ld_valid_q <= 1'b1;
            ld_busy_q  <= 1'b0;
            state_q    <= IDLE;
`else
            wr_addr_q <= head_addr;
            wr_data_q <= head_data;
            state_q   <= W_SETUP;
`endif
          end else begin
            rd_addr_q <= ld_addr_q;
            state_q   <= LD_CAP;
          end
        end
        LD_CAP: begin
          ld_data_q  <= bus.dm_read_data_i;
          ld_valid_q <= 1'b1;
          ld_busy_q  <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - directed self-checking bench for dm_store_buffer
// Data memory model commits on the falling edge of dm_we and reads combinationally.
module tb_dm_store_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_store_buffer_if bus ();
  dm_store_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [65536];
  logic [15:0] wlog_a [$];
  logic [31:0] wlog_d [$];
  int we_pulses = 0;
  int total = 0;
  int bad = 0;

  assign bus.dm_read_data_i = mem[bus.dm_read_addr_o];

  always @(negedge bus.dm_we_o) begin
    mem[bus.dm_write_addr_o] = bus.dm_write_data_o;
    wlog_a.push_back(bus.dm_write_addr_o);
    wlog_d.push_back(bus.dm_write_data_o);
  end

  always @(posedge bus.dm_we_o) we_pulses++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while ((bus.buf_count_o != 0 || bus.ld_busy_o) && n < 100) begin
      cyc(1);
      n++;
    end
    cyc(2);
    check_eq(tag, bus.buf_count_o, 0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.ld_valid_o && lat < 40) begin
      cyc(1);
      lat++;
    end
  endtask

  int lat;
  int n;
  int p0;
  bit saw_full;

  initial begin
    bus.st_req_i  = 1'b0;
    bus.st_addr_i = '0;
    bus.st_data_i = '0;
    bus.ld_req_i  = 1'b0;
    bus.ld_addr_i = '0;
    mem[16'h0020] = 32'h12345678;
    mem[16'h0030] = 32'h0;
    mem[16'h0040] = 32'h0;
    rst = 1'b1;
    cyc(2);
    check_eq("rst_st_ready", bus.st_ready_o, 1);
    check_eq("rst_ld_busy", bus.ld_busy_o, 0);
    check_eq("rst_ld_valid", bus.ld_valid_o, 0);
    check_eq("rst_ld_data", bus.ld_data_o, 0);
    check_eq("rst_dm_we", bus.dm_we_o, 0);
    check_eq("rst_rd_addr", bus.dm_read_addr_o, 0);
    check_eq("rst_wr_addr", bus.dm_write_addr_o, 0);
    check_eq("rst_count", bus.buf_count_o, 0);
    rst = 1'b0;
    cyc(2);

    // single store into an idle buffer
    p0 = we_pulses;
    bus.st_req_i = 1'b1; bus.st_addr_i = 16'h0010; bus.st_data_i = 32'hDEADBEEF;
    cyc(1);
    bus.st_req_i = 1'b0;
    check_eq("st_n1_we", bus.dm_we_o, 0);
    check_eq("st_n1_addr", bus.dm_write_addr_o, 16'h0010);
    check_eq("st_n1_count", bus.buf_count_o, 1);
    cyc(1);
    check_eq("st_n2_we", bus.dm_we_o, 1);
    check_eq("st_n2_data", bus.dm_write_data_o, 32'hDEADBEEF);
    cyc(1);
    check_eq("st_n3_we", bus.dm_we_o, 0);
    check_eq("st_n3_addr", bus.dm_write_addr_o, 16'h0010);
    cyc(1);
    check_eq("st_n4_count", bus.buf_count_o, 0);
    check_eq("st_mem", mem[16'h0010], 32'hDEADBEEF);
    check_eq("st_pulses", we_pulses - p0, 1);

    // load miss, empty buffer
    bus.ld_req_i = 1'b1; bus.ld_addr_i = 16'h0020;
    cyc(1);
    bus.ld_req_i = 1'b0;
    check_eq("ld_n1_busy", bus.ld_busy_o, 1);
    cyc(1);
    check_eq("ld_n2_valid", bus.ld_valid_o, 0);
    check_eq("ld_n2_rdaddr", bus.dm_read_addr_o, 16'h0020);
    cyc(1);
    check_eq("ld_n3_valid", bus.ld_valid_o, 1);
    check_eq("ld_n3_data", bus.ld_data_o, 32'h12345678);
    check_eq("ld_n3_busy", bus.ld_busy_o, 0);
    cyc(1);
    check_eq("ld_n4_valid", bus.ld_valid_o, 0);
    check_eq("ld_n4_hold", bus.ld_data_o, 32'h12345678);

    // same-cycle store and load to the same address
    bus.st_req_i = 1'b1; bus.st_addr_i = 16'h0030; bus.st_data_i = 32'hA5A5A5A5;
    bus.ld_req_i = 1'b1; bus.ld_addr_i = 16'h0030;
    cyc(1);
    bus.st_req_i = 1'b0; bus.ld_req_i = 1'b0;
    wait_valid(lat);
    check_eq("haz_data", bus.ld_data_o, 32'hA5A5A5A5);
`ifdef LOAD_FORWARD_EN
    check_eq("haz_lat", lat, 2);
    check_eq("haz_rdaddr", bus.dm_read_addr_o, 16'h0020);
`else
    check_eq("haz_lat", lat, 8);
    check_eq("haz_rdaddr", bus.dm_read_addr_o, 16'h0030);
`endif
    wait_drained("haz_drain");
    check_eq("haz_mem", mem[16'h0030], 32'hA5A5A5A5);

    // two stores to one address, youngest wins
    bus.st_req_i = 1'b1; bus.st_addr_i = 16'h0040; bus.st_data_i = 32'h1;
    cyc(1);
    bus.st_data_i = 32'h2;
    cyc(1);
    bus.st_req_i = 1'b0;
    bus.ld_req_i = 1'b1; bus.ld_addr_i = 16'h0040;
    cyc(1);
    bus.ld_req_i = 1'b0;
    wait_valid(lat);
    check_eq("young_valid", bus.ld_valid_o, 1);
    check_eq("young_data", bus.ld_data_o, 32'h2);
    wait_drained("young_drain");
    check_eq("young_mem", mem[16'h0040], 32'h2);

    // back-to-back stores beyond DEPTH: back-pressure, order kept
    wlog_a.delete();
    wlog_d.delete();
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.st_req_i  = 1'b1;
      bus.st_addr_i = 16'h0100 + 16'(i);
      bus.st_data_i = 32'hC0DE0000 + 32'(i);
      n = 0;
      while (!bus.st_ready_o && n < 50) begin
        saw_full = 1'b1;
        cyc(1);
        n++;
      end
      cyc(1);
    end
    bus.st_req_i = 1'b0;
    check_eq("bp_saw_full", saw_full, 1);
    wait_drained("bp_drain");
    check_eq("bp_nwrites", wlog_a.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wlog_a.size()) begin
        check_eq($sformatf("bp_addr%0d", i), wlog_a[i], 16'h0100 + 16'(i));
        check_eq($sformatf("bp_data%0d", i), wlog_d[i], 32'hC0DE0000 + 32'(i));
      end
    end

    // reset while draining with three buffered entries
    bus.ld_req_i = 1'b1; bus.ld_addr_i = 16'h0020;
    bus.st_req_i = 1'b1; bus.st_addr_i = 16'h0050; bus.st_data_i = 32'h11;
    cyc(1);
    bus.ld_req_i = 1'b0; bus.st_addr_i = 16'h0051;
    cyc(1);
    bus.st_addr_i = 16'h0052;
    cyc(1);
    bus.st_req_i = 1'b0;
    check_eq("rm_count3", bus.buf_count_o, 3);
    cyc(1);
    check_eq("rm_setup_addr", bus.dm_write_addr_o, 16'h0050);
    check_eq("rm_setup_we", bus.dm_we_o, 0);
    p0 = we_pulses;
    rst = 1'b1;
    #1;
    check_eq("rm_count", bus.buf_count_o, 0);
    check_eq("rm_ready", bus.st_ready_o, 1);
    check_eq("rm_we", bus.dm_we_o, 0);
    check_eq("rm_busy", bus.ld_busy_o, 0);
    cyc(2);
    rst = 1'b0;
    cyc(10);
    check_eq("rm_no_pulses", we_pulses - p0, 0);
    check_eq("rm_count_after", bus.buf_count_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
